// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register width,
// hazard FSM states and per-hazard stall lengths.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam int STALL_LOAD_USE    = 1;
    localparam int STALL_BR_ALU      = 1;
    localparam int STALL_BR_LOAD_EX  = 2;
    localparam int STALL_BR_LOAD_MEM = 1;

endpackage

// File: rtl/hazard_detect_comb.sv
// Combinational hazard match against the EX and MEM destinations and the
// resulting stall length for the instruction sitting in ID.
module hazard_detect_comb #(
    parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  id_use_rt,
    input  logic                  id_branch,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_regwrite,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_memread,
    output logic                  hit_ex,
    output logic                  hit_mem,
    output logic [CNT_W-1:0]      n_stall
);
    import mips_pipe_pkg::*;

    // $0 is hardwired, so a zero destination never matches; rs and rt
    // matching the same rd collapse into a single hit.
    always_comb begin
        hit_ex  = (id_ex_rd != '0) &&
                  ((id_ex_rd == if_id_rs) || (id_use_rt && (id_ex_rd == if_id_rt)));
        hit_mem = (ex_mem_rd != '0) &&
                  ((ex_mem_rd == if_id_rs) || (id_use_rt && (ex_mem_rd == if_id_rt)));

        n_stall = '0;
        if (id_branch && hit_ex && id_ex_memread)
            n_stall = CNT_W'(STALL_BR_LOAD_EX);
        else if (id_branch && hit_ex && id_ex_regwrite)
            n_stall = CNT_W'(STALL_BR_ALU);
        else if (id_branch && hit_mem && ex_mem_memread)
            n_stall = CNT_W'(STALL_BR_LOAD_MEM);
        else if (!id_branch && hit_ex && id_ex_memread)
            n_stall = CNT_W'(STALL_LOAD_USE);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard sequencer: load-use / branch-dependency stalls, taken-branch
// IF flush and memory-busy freeze. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 2,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  id_use_rt,
    input  logic                  id_branch,
    input  logic                  branch_taken,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_regwrite,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_memread,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_flush,
    output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_count
`endif
);
    import mips_pipe_pkg::*;

    logic             hit_ex;
    logic             hit_mem;
    logic [CNT_W-1:0] n_stall;
    logic             stall_req;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hazard_detect_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_detect (
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_use_rt      (id_use_rt),
        .id_branch      (id_branch),
        .id_ex_rd       (id_ex_rd),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_memread (ex_mem_memread),
        .hit_ex         (hit_ex),
        .hit_mem        (hit_mem),
        .n_stall        (n_stall)
    );

    assign stall_req = (hit_ex || hit_mem) && (n_stall != '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if_flush     = 1'b0;
        if (!rst_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (mem_busy) begin
            // Freeze: hold everything; a pending flush reappears once released.
            id_ex_bubble = 1'b0;
        end else if (state_q == ST_STALL) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (stall_req) begin
            // Only stalls longer than one cycle need the counter.
            if (n_stall > CNT_W'(1)) begin
                state_d = ST_STALL;
                cnt_d   = n_stall - CNT_W'(1);
            end
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_flush     = id_branch && branch_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_active = (state_q == ST_STALL);

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
            flush_count_d  = '0;
        end else begin
            if (!pc_write && !mem_busy)
                stall_cycles_d = stall_cycles_q + PERF_W'(1);
            if (if_flush)
                flush_count_d = flush_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan scenarios followed by random
// traffic against a cycle-level reference model (HAZARD_PERF_CNT_EN aware).
module tb_hazard_stall_ctrl;

    localparam int RW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic          id_use_rt, id_branch, branch_taken;
    logic          id_ex_regwrite, id_ex_memread, ex_mem_memread, mem_busy;
    logic          pc_write, if_id_write, id_ex_bubble, if_flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
    logic          perf_clr;
    logic [PW-1:0] stall_cycles, flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stall cycles still owed beyond the current one, plus perf tallies.
    int          m_owed = 0;
    int unsigned m_stalls = 0;
    int unsigned m_flushes = 0;

    hazard_stall_ctrl #(.REG_ADDR_W(RW), .CNT_W(2), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_use_rt      (id_use_rt),
        .id_branch      (id_branch),
        .branch_taken   (branch_taken),
        .id_ex_rd       (id_ex_rd),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_memread (ex_mem_memread),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_flush       (if_flush),
        .stall_active   (stall_active)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_clr       (perf_clr),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [RW-1:0] rd);
        return (rd != 0) && (rd == if_id_rs || (id_use_rt && rd == if_id_rt));
    endfunction

    // Stall cycles demanded by the ID instruction, straight from the hazard rules.
    function automatic int need_cycles();
        bit ex_dep  = reads(id_ex_rd);
        bit mem_dep = reads(ex_mem_rd);
        if (id_branch) begin
            if (ex_dep && id_ex_memread)   return 2;
            if (ex_dep && id_ex_regwrite)  return 1;
            if (mem_dep && ex_mem_memread) return 1;
            return 0;
        end
        return (ex_dep && id_ex_memread) ? 1 : 0;
    endfunction

    task automatic clear_inputs();
        if_id_rs = 0; if_id_rt = 0; id_ex_rd = 0; ex_mem_rd = 0;
        id_use_rt = 0; id_branch = 0; branch_taken = 0;
        id_ex_regwrite = 0; id_ex_memread = 0; ex_mem_memread = 0; mem_busy = 0;
`ifdef HAZARD_PERF_CNT_EN
        perf_clr = 0;
`endif
    endtask

    // One pipeline cycle: inputs already set just after the previous edge.
    task automatic cycle(input string tag);
        logic [4:0] exp;
        int need;
        int next_owed;
        bit stall_now;
        need      = need_cycles();
        next_owed = m_owed;
        if (!rst_n) begin
            exp = 5'b00100; next_owed = 0;
        end else if (mem_busy) begin
            exp = {4'b0000, m_owed > 0};
        end else if (m_owed > 0) begin
            exp = 5'b00101; next_owed = m_owed - 1;
        end else if (need > 0) begin
            exp = 5'b00100; next_owed = need - 1;
        end else begin
            exp = {3'b110, id_branch && branch_taken, 1'b0};
        end
        @(negedge clk);
        chk(tag, {pc_write, if_id_write, id_ex_bubble, if_flush, stall_active}, exp);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stallcnt"}, stall_cycles, m_stalls);
        chk({tag, "_flushcnt"}, flush_count, m_flushes);
`endif
        stall_now = rst_n && !mem_busy && !exp[4];
        @(posedge clk);
        #1;
        m_owed = rst_n ? next_owed : 0;
`ifdef HAZARD_PERF_CNT_EN
        if (!rst_n || perf_clr) begin
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (stall_now) m_stalls++;
            if (exp[1])    m_flushes++;
        end
`else
        if (stall_now) m_stalls++;
`endif
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) cycle("reset");
        rst_n = 1'b1;
        cycle("idle");

        // Load-use
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 8; if_id_rs = 8;
        cycle("lu_stall");
        clear_inputs(); if_id_rs = 8; ex_mem_rd = 8; ex_mem_memread = 1;
        cycle("lu_resume");

        // Branch after load in EX: Mealy stall then one STALL cycle
        clear_inputs();
        id_branch = 1; branch_taken = 1; id_use_rt = 1; if_id_rt = 9;
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 9;
        cycle("brld_mealy");
        cycle("brld_stall");
        id_ex_memread = 0; id_ex_regwrite = 0; id_ex_rd = 0;
        cycle("brld_flush");
        clear_inputs();
        cycle("brld_after");

        // Branch after ALU, taken
        id_branch = 1; branch_taken = 1; id_ex_regwrite = 1; id_ex_rd = 3; if_id_rs = 3;
        cycle("bralu_stall");
        id_ex_regwrite = 0; id_ex_rd = 0;
        cycle("bralu_flush");
        clear_inputs();
        cycle("bralu_after");

        // $0 never stalls, then freeze in the middle of STALL
        id_ex_memread = 1; id_ex_rd = 0; if_id_rs = 0;
        cycle("zero_reg");
        clear_inputs();
        id_branch = 1; id_ex_memread = 1; id_ex_rd = 5; if_id_rs = 5;
        cycle("frz_mealy");
        mem_busy = 1;
        repeat (3) cycle("frz_busy");
        mem_busy = 0;
        cycle("frz_stall");
        clear_inputs();
        cycle("frz_after");

        // Reset in the middle of a stall
        id_branch = 1; id_ex_memread = 1; id_ex_rd = 6; if_id_rs = 6;
        cycle("rst_mealy");
        #1 rst_n = 1'b0;
        cycle("rst_hold");
        clear_inputs();
        rst_n = 1'b1;
        cycle("rst_release");

`ifdef HAZARD_PERF_CNT_EN
        perf_clr = 1;
        cycle("perf_clr0");
        clear_inputs();
        id_ex_memread = 1; id_ex_rd = 8; if_id_rs = 8;
        cycle("perf_lu");
        clear_inputs();
        id_branch = 1; branch_taken = 1; id_ex_regwrite = 1; id_ex_rd = 3; if_id_rs = 3;
        cycle("perf_bralu");
        id_ex_regwrite = 0; id_ex_rd = 0;
        cycle("perf_flush");
        clear_inputs();
        @(negedge clk);
        chk("perf_stall_total", stall_cycles, 32'd2);
        chk("perf_flush_total", flush_count, 32'd1);
        @(posedge clk); #1;
        perf_clr = 1;
        cycle("perf_clr1");
        perf_clr = 0;
        @(negedge clk);
        chk("perf_stall_zero", stall_cycles, 32'd0);
        chk("perf_flush_zero", flush_count, 32'd0);
        @(posedge clk); #1;
        m_stalls = 0; m_flushes = 0;
        if (!pc_write) m_stalls = 0;
`endif

        // Random traffic over a small register window to provoke frequent hits
        for (int i = 0; i < 3000; i++) begin
            if_id_rs       = RW'($urandom_range(0, 3));
            if_id_rt       = RW'($urandom_range(0, 3));
            id_ex_rd       = RW'($urandom_range(0, 3));
            ex_mem_rd      = RW'($urandom_range(0, 3));
            id_use_rt      = 1'($urandom_range(0, 1));
            id_branch      = ($urandom_range(0, 2) == 0);
            branch_taken   = 1'($urandom_range(0, 1));
            id_ex_regwrite = 1'($urandom_range(0, 1));
            id_ex_memread  = ($urandom_range(0, 2) == 0);
            ex_mem_memread = ($urandom_range(0, 2) == 0);
            mem_busy       = ($urandom_range(0, 5) == 0);
            rst_n          = ($urandom_range(0, 60) != 0);
`ifdef HAZARD_PERF_CNT_EN
            perf_clr       = ($urandom_range(0, 30) == 0);
`endif
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
